// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port RAM slice.
package ram_pkg;

  // Controller states: INIT clears the array, READY serves user traffic.
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  // Same-address read-during-write selection.
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/ram_init_seq.sv
// Clear sequencer: after reset, walks every address once writing zero,
// then hands the array over to user traffic.
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output state_t                state,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  init_busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   counter;
  logic [ADDR_WIDTH-1:0]   counter_next;
  logic                    busy_next;

  // The clear write targets the current counter value on every INIT edge.
  assign clr_we   = (state == INIT);
  assign clr_addr = counter;

  // Next-state: step the counter through the array, stop on the last word
  // without wrapping, and drop busy together with the move to READY.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    busy_next    = init_busy;
    case (state)
      INIT: begin
        if (counter == LAST_ADDR) begin
          state_next = READY;
          busy_next  = 1'b0;
        end else begin
          counter_next = counter + 1'b1;
        end
      end
      READY: begin
        state_next = READY;
      end
      default: begin
        state_next = INIT;
      end
    endcase
  end

  // State register; reset restarts the clear from address 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      counter   <= '0;
      init_busy <= 1'b1;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      init_busy <= busy_next;
    end
  end

endmodule

// File: rtl/ram_dual_port.sv
// Simple dual-port RAM: one write port with byte enables, one registered
// read port, self-clearing after reset.
//
// Read protocol: a read is accepted on any rising edge with re=1 while the
// array is READY; dout carries the word and dout_valid is high for exactly
// the following cycle. There is no backpressure. While the clear runs
// (init_busy=1) both we and re are ignored.
module ram_dual_port
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_valid,
  output logic                    init_busy
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  ready;
  logic                  user_wr;
  logic                  user_rd;
  logic [DATA_WIDTH-1:0] rd_word;

  ram_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .state     (state),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_busy (init_busy)
  );

  assign ready   = (state == READY);
  assign user_wr = rst_n && ready && we;
  assign user_rd = ready && re;

  // Read word selection: the array gives the pre-write word; in new-data
  // mode a colliding write is merged in byte by byte.
  always_comb begin
    rd_word = mem[raddr];
    if (RDW_MODE == RDW_NEW && we && (waddr == raddr)) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wbe[i]) rd_word[8*i +: 8] = din[8*i +: 8];
      end
    end
  end

  // Storage: clear writes during INIT, masked user writes during READY.
  always_ff @(posedge clk) begin
    if (rst_n && clr_we) begin
      mem[clr_addr] <= '0;
    end else if (user_wr) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

  // Registered read port: dout holds between reads, valid pulses per read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (user_rd) begin
      dout       <= rd_word;
      dout_valid <= 1'b1;
    end else begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_dual_port.sv
// Directed bench for ram_dual_port: an 8-bit old-data instance and a 16-bit
// new-data instance share the clock and reset.
module tb_ram_dual_port;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit, RDW_MODE=0 instance
  logic       we = 1'b0;
  logic [0:0] wbe = '0;
  logic [3:0] waddr = '0;
  logic [7:0] din = '0;
  logic       re = 1'b0;
  logic [3:0] raddr = '0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       init_busy;

  // 16-bit, RDW_MODE=1 instance
  logic        we16 = 1'b0;
  logic [1:0]  wbe16 = '0;
  logic [3:0]  waddr16 = '0;
  logic [15:0] din16 = '0;
  logic        re16 = 1'b0;
  logic [3:0]  raddr16 = '0;
  logic [15:0] dout16;
  logic        dout_valid16;
  logic        init_busy16;

  int pass_cnt = 0;
  int total_cnt = 0;

  ram_dual_port #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RDW_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wbe(wbe), .waddr(waddr), .din(din),
    .re(re), .raddr(raddr), .dout(dout), .dout_valid(dout_valid),
    .init_busy(init_busy)
  );

  ram_dual_port #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .we(we16), .wbe(wbe16), .waddr(waddr16),
    .din(din16), .re(re16), .raddr(raddr16), .dout(dout16),
    .dout_valid(dout_valid16), .init_busy(init_busy16)
  );

  // Driver tasks: all start and end on a falling edge.
  task automatic idle_inputs();
    we = 1'b0; wbe = '0; waddr = '0; din = '0; re = 1'b0; raddr = '0;
    we16 = 1'b0; wbe16 = '0; waddr16 = '0; din16 = '0; re16 = 1'b0; raddr16 = '0;
  endtask

  task automatic wr8(input logic [3:0] a, input logic [7:0] d);
    we = 1'b1; wbe = 1'b1; waddr = a; din = d;
    @(negedge clk);
    we = 1'b0; wbe = '0;
  endtask

  task automatic rd8(input logic [3:0] a, output logic [7:0] d, output logic v);
    re = 1'b1; raddr = a;
    @(negedge clk);
    d = dout; v = dout_valid;
    re = 1'b0;
  endtask

  task automatic wr16(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    we16 = 1'b1; wbe16 = be; waddr16 = a; din16 = d;
    @(negedge clk);
    we16 = 1'b0; wbe16 = '0;
  endtask

  task automatic rd16(input logic [3:0] a, output logic [15:0] d, output logic v);
    re16 = 1'b1; raddr16 = a;
    @(negedge clk);
    d = dout16; v = dout_valid16;
    re16 = 1'b0;
  endtask

  // Releases reset and counts cycles with init_busy high, bounded.
  task automatic wait_init(output int cycles);
    rst_n = 1'b1;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!init_busy) break;
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int cyc;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (dout !== 8'h00) $display("FAIL reset_dout: got %h expected 00", dout);
    else pass_cnt++;
    total_cnt++;
    if (dout_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", dout_valid);
    else pass_cnt++;
    total_cnt++;
    if (init_busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", init_busy);
    else pass_cnt++;
    total_cnt++;
    if (dout16 !== 16'h0000 || init_busy16 !== 1'b1)
      $display("FAIL reset_16: got dout %h busy %b expected 0000 1", dout16, init_busy16);
    else pass_cnt++;
    wait_init(cyc);
    total_cnt++;
    if (cyc !== 16) $display("FAIL init_length: got %0d cycles expected 16", cyc);
    else pass_cnt++;
    total_cnt++;
    if (init_busy16 !== 1'b0) $display("FAIL init_done_16: got busy %b expected 0", init_busy16);
    else pass_cnt++;
  endtask

  task automatic test_init_clear();
    logic [7:0] d;
    logic v;
    for (int a = 0; a < 16; a++) begin
      rd8(4'(a), d, v);
      total_cnt++;
      if ({v, d} !== {1'b1, 8'h00})
        $display("FAIL clear_read[%0d]: got valid %b dout %h expected 1 00", a, v, d);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if (dout_valid !== 1'b0) $display("FAIL valid_drop: got %b expected 0", dout_valid);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    logic [7:0] d;
    logic v;
    wr8(4'h3, 8'hAA);
    wr8(4'h5, 8'h55);
    rd8(4'h3, d, v);
    total_cnt++;
    if ({v, d} !== {1'b1, 8'hAA}) $display("FAIL read_3: got %b %h expected 1 aa", v, d);
    else pass_cnt++;
    rd8(4'h5, d, v);
    total_cnt++;
    if ({v, d} !== {1'b1, 8'h55}) $display("FAIL read_5: got %b %h expected 1 55", v, d);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({dout_valid, dout} !== {1'b0, 8'h55})
      $display("FAIL dout_hold: got %b %h expected 0 55", dout_valid, dout);
    else pass_cnt++;
  endtask

  task automatic test_diff_addr();
    logic [7:0] d;
    logic v;
    we = 1'b1; wbe = 1'b1; waddr = 4'h8; din = 8'h3C;
    re = 1'b1; raddr = 4'h3;
    @(negedge clk);
    idle_inputs();
    total_cnt++;
    if ({dout_valid, dout} !== {1'b1, 8'hAA})
      $display("FAIL diff_addr_read: got %b %h expected 1 aa", dout_valid, dout);
    else pass_cnt++;
    rd8(4'h8, d, v);
    total_cnt++;
    if ({v, d} !== {1'b1, 8'h3C}) $display("FAIL diff_addr_write: got %b %h expected 1 3c", v, d);
    else pass_cnt++;
  endtask

  task automatic test_byte_mask();
    logic [15:0] d;
    logic v;
    wr16(4'h2, 16'h1234, 2'b11);
    wr16(4'h2, 16'hABCD, 2'b01);
    rd16(4'h2, d, v);
    total_cnt++;
    if ({v, d} !== {1'b1, 16'h12CD}) $display("FAIL mask_low: got %b %h expected 1 12cd", v, d);
    else pass_cnt++;
    wr16(4'h2, 16'hFFFF, 2'b00);
    rd16(4'h2, d, v);
    total_cnt++;
    if ({v, d} !== {1'b1, 16'h12CD}) $display("FAIL mask_none: got %b %h expected 1 12cd", v, d);
    else pass_cnt++;
    wr16(4'h2, 16'h5600, 2'b10);
    rd16(4'h2, d, v);
    total_cnt++;
    if ({v, d} !== {1'b1, 16'h56CD}) $display("FAIL mask_high: got %b %h expected 1 56cd", v, d);
    else pass_cnt++;
  endtask

  task automatic test_rdw();
    logic [7:0] d;
    logic [15:0] d16;
    logic v;
    wr8(4'h7, 8'h11);
    we = 1'b1; wbe = 1'b1; waddr = 4'h7; din = 8'h22;
    re = 1'b1; raddr = 4'h7;
    @(negedge clk);
    idle_inputs();
    total_cnt++;
    if ({dout_valid, dout} !== {1'b1, 8'h11})
      $display("FAIL rdw_old: got %b %h expected 1 11", dout_valid, dout);
    else pass_cnt++;
    rd8(4'h7, d, v);
    total_cnt++;
    if ({v, d} !== {1'b1, 8'h22}) $display("FAIL rdw_old_after: got %b %h expected 1 22", v, d);
    else pass_cnt++;
    wr16(4'h7, 16'h1111, 2'b11);
    we16 = 1'b1; wbe16 = 2'b01; waddr16 = 4'h7; din16 = 16'h2222;
    re16 = 1'b1; raddr16 = 4'h7;
    @(negedge clk);
    idle_inputs();
    total_cnt++;
    if ({dout_valid16, dout16} !== {1'b1, 16'h1122})
      $display("FAIL rdw_new: got %b %h expected 1 1122", dout_valid16, dout16);
    else pass_cnt++;
    rd16(4'h7, d16, v);
    total_cnt++;
    if ({v, d16} !== {1'b1, 16'h1122}) $display("FAIL rdw_new_after: got %b %h expected 1 1122", v, d16);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_init();
    logic [7:0] d;
    logic v;
    int cyc;
    wr8(4'h4, 8'h99);
    wr8(4'hF, 8'h77);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total_cnt++;
    if (init_busy !== 1'b1) $display("FAIL mid_init_busy: got %b expected 1", init_busy);
    else pass_cnt++;
    rst_n = 1'b0;
    @(negedge clk);
    wait_init(cyc);
    total_cnt++;
    if (cyc !== 16) $display("FAIL restart_length: got %0d cycles expected 16", cyc);
    else pass_cnt++;
    rd8(4'h4, d, v);
    total_cnt++;
    if ({v, d} !== {1'b1, 8'h00}) $display("FAIL restart_read_4: got %b %h expected 1 00", v, d);
    else pass_cnt++;
    rd8(4'hF, d, v);
    total_cnt++;
    if ({v, d} !== {1'b1, 8'h00}) $display("FAIL restart_read_f: got %b %h expected 1 00", v, d);
    else pass_cnt++;
  endtask

  task automatic test_init_ignore();
    logic [7:0] d;
    logic v;
    int cyc;
    int bad;
    rst_n = 1'b0;
    @(negedge clk);
    we = 1'b1; wbe = 1'b1; waddr = 4'h3; din = 8'hFF;
    re = 1'b1; raddr = 4'h3;
    rst_n = 1'b1;
    cyc = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (!init_busy) break;
      if (dout_valid !== 1'b0 || dout !== 8'h00) bad++;
      cyc++;
      @(negedge clk);
    end
    idle_inputs();
    total_cnt++;
    if (bad !== 0) $display("FAIL init_ignore_outputs: got %0d bad cycles expected 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (cyc !== 16) $display("FAIL init_ignore_length: got %0d cycles expected 16", cyc);
    else pass_cnt++;
    rd8(4'h3, d, v);
    total_cnt++;
    if ({v, d} !== {1'b1, 8'h00}) $display("FAIL init_ignore_read_3: got %b %h expected 1 00", v, d);
    else pass_cnt++;
  endtask

  // Sequencer and final report
  initial begin
    test_reset();
    test_init_clear();
    test_write_read();
    test_diff_addr();
    test_byte_mask();
    test_rdw();
    test_reset_mid_init();
    test_init_ignore();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
